// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: single-port data memory for the CPU load/store stage.
// Byte-lane stores, registered one-cycle load responses (raw / aligned zero-ext /
// aligned sign-ext), a whole-array clear sequencer and a combinational debug port.
// Optional macro DMEM_STATS_EN builds saturating load/store counters; without it
// rd_count and wr_count are tied to zero.
// Handshake: a request is accepted on a rising edge where req_valid && req_ready;
// req_valid and the request fields must hold until that edge. Exactly one
// rsp_valid pulse follows each accepted request, in the next cycle.
module data_memory_ctrl #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int INIT_CLEAR = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wr,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [1:0]            rd_mode,
    input  logic                  mem_clr,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rsp_err,
    output logic                  busy,
    input  logic [ADDR_W-1:0]     show_addr,
    output logic [DATA_W-1:0]     show_data,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
);
    localparam int LANES = DATA_W / 8;
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {ST_IDLE, ST_CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                accept;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   word, raw_word, shifted, aligned_word;
    logic                contig, fill_bit;
    int                  lo, hi;

    // FSM next state, clear pointer and handshake outputs
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = !mem_clr;
                if (mem_clr) begin
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                end
            end
            ST_CLEAR: begin
                busy = 1'b1;
                if (ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept = req_valid && req_ready;

    // Load formatting: lane span, contiguity check and the three result forms
    always_comb begin
        word     = mem[addr];
        raw_word = '0;
        lo       = 0;
        hi       = 0;
        contig   = 1'b1;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (be[i]) begin
                raw_word[8*i +: 8] = word[8*i +: 8];
                lo = i;
            end
        end
        for (int i = 0; i < LANES; i++) begin
            if (be[i]) hi = i;
        end
        for (int i = 0; i < LANES; i++) begin
            if (be[i] != ((i >= lo) && (i <= hi))) contig = 1'b0;
        end
        shifted      = word >> (8 * lo);
        fill_bit     = (rd_mode == 2'd2) ? word[8*hi + 7] : 1'b0;
        aligned_word = '0;
        for (int j = 0; j < LANES; j++) begin
            if (j <= hi - lo) aligned_word[8*j +: 8] = shifted[8*j +: 8];
            else              aligned_word[8*j +: 8] = {8{fill_bit}};
        end

        rsp_valid_d = accept;
        rdata_d     = '0;
        rsp_err_d   = 1'b0;
        if (accept && !req_wr) begin
            if (be == '0) begin
                rsp_err_d = 1'b1;
            end else if (rd_mode == 2'd1 || rd_mode == 2'd2) begin
                rdata_d   = contig ? aligned_word : raw_word;
                rsp_err_d = !contig;
            end else begin
                rdata_d = raw_word;
            end
        end
    end

    // FSM, pointer and response registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= (INIT_CLEAR != 0) ? ST_CLEAR : ST_IDLE;
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Array writes: clear sequencer has priority, otherwise byte-lane stores
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[ptr_q] <= '0;
        end else if (accept && req_wr) begin
            for (int i = 0; i < LANES; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rdata     = rdata_q;
    assign rsp_err   = rsp_err_q;
    assign show_data = mem[show_addr];

`ifdef DMEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    // Saturating counts of accepted loads and stores
    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (accept && !req_wr && rd_count_q != 32'hFFFF_FFFF) rd_count_d = rd_count_q + 32'd1;
        if (accept &&  req_wr && wr_count_q != 32'hFFFF_FFFF) wr_count_d = wr_count_q + 32'd1;
    end

    // Counter registers, cleared only by clr
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl (ADDR_W=4, DATA_W=32, INIT_CLEAR=1).
// A word-array model plus a load-result function computed with plain shifts and
// masks supply every expected value; one compare process checks responses and
// counters each cycle, directed sections check clear timing and the debug port.
module tb_data_memory_ctrl;
    localparam int AW = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          clr;
    logic          req_valid, req_wr, mem_clr;
    logic          req_ready, rsp_valid, rsp_err, busy;
    logic [AW-1:0] addr, show_addr;
    logic [DW-1:0] wdata, rdata, show_data;
    logic [3:0]    be;
    logic [1:0]    rd_mode;
    logic [31:0]   rd_count, wr_count;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] model_mem [16];
    logic [DW:0]   exp_q [$];
    int unsigned   mdl_rd = 0;
    int unsigned   mdl_wr = 0;
    logic          chk_en = 1'b0;

    data_memory_ctrl #(.ADDR_W(AW), .DATA_W(DW), .INIT_CLEAR(1)) dut (
        .clk(clk), .clr(clr), .req_valid(req_valid), .req_ready(req_ready),
        .req_wr(req_wr), .addr(addr), .wdata(wdata), .be(be), .rd_mode(rd_mode),
        .mem_clr(mem_clr), .rsp_valid(rsp_valid), .rdata(rdata), .rsp_err(rsp_err),
        .busy(busy), .show_addr(show_addr), .show_data(show_data),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Expected {err, rdata} of a load, from the lane rules
    function automatic logic [DW:0] model_load(input logic [31:0] w, input logic [3:0] b,
                                               input logic [1:0] m);
        logic [31:0] raw;
        logic [63:0] v, msk;
        logic [3:0]  s;
        int          lo, n;
        raw = '0;
        for (int i = 0; i < 4; i++) if (b[i]) raw[8*i +: 8] = w[8*i +: 8];
        if (b == 4'b0) return {1'b1, 32'h0};
        if (m != 2'd1 && m != 2'd2) return {1'b0, raw};
        lo = 0;
        while (!b[lo]) lo++;
        s = b >> lo;
        if ((s & (s + 4'd1)) != 4'd0) return {1'b1, raw};
        n   = $countones(s);
        v   = {32'h0, w} >> (8 * lo);
        msk = (64'd1 << (8 * n)) - 64'd1;
        v   = v & msk;
        if (m == 2'd2 && v[8*n-1]) v = v | ~msk;
        return {1'b0, v[31:0]};
    endfunction

    // Compare process: responses and counters every cycle
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            logic [DW:0] e;
            check("rsp_valid", {63'b0, rsp_valid}, {63'b0, exp_q.size() > 0});
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (rsp_valid) begin
                    check("rdata", {32'b0, rdata}, {32'b0, e[DW-1:0]});
                    check("rsp_err", {63'b0, rsp_err}, {63'b0, e[DW]});
                end
            end
`ifdef DMEM_STATS_EN
            check("rd_count", {32'b0, rd_count}, {32'b0, mdl_rd});
            check("wr_count", {32'b0, wr_count}, {32'b0, mdl_wr});
`else
            check("rd_count", {32'b0, rd_count}, 64'd0);
            check("wr_count", {32'b0, wr_count}, 64'd0);
`endif
        end
    end

    // Issue one request and record its expected response at the accept edge
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [31:0] d,
                          input logic [3:0] b, input logic [1:0] m);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; addr = a; wdata = d; be = b; rd_mode = m;
        n = 0;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!req_ready) begin
            check("req_ready_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (wr) begin
            for (int i = 0; i < 4; i++) if (b[i]) model_mem[a][8*i +: 8] = d[8*i +: 8];
            exp_q.push_back({1'b0, 32'h0});
            mdl_wr++;
        end else begin
            exp_q.push_back(model_load(model_mem[a], b, m));
            mdl_rd++;
        end
        #1;
        req_valid = 1'b0;
    endtask

    // Count busy cycles from the current point; req_ready must stay low meanwhile
    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 100) begin
            if (n == 0) check("ready_low_in_clear", {63'b0, req_ready}, 64'd0);
            n++;
            @(negedge clk); #1;
        end
    endtask

    task automatic check_show_all;
        for (int a = 0; a < 16; a++) begin
            show_addr = a[AW-1:0];
            #1;
            check("show_data", {32'b0, show_data}, {32'b0, model_mem[a]});
        end
    endtask

    initial begin
        int n;
        clr = 1'b1; req_valid = 1'b0; req_wr = 1'b0; addr = '0; wdata = '0; be = '0;
        rd_mode = '0; mem_clr = 1'b0; show_addr = '0;
        for (int a = 0; a < 16; a++) model_mem[a] = '0;

        // T1: reset values, 16-cycle initial clear, array zero
        repeat (2) @(negedge clk);
        #1;
        check("rst_rsp_valid", {63'b0, rsp_valid}, 64'd0);
        check("rst_rdata", {32'b0, rdata}, 64'd0);
        check("rst_rsp_err", {63'b0, rsp_err}, 64'd0);
        check("rst_rd_count", {32'b0, rd_count}, 64'd0);
        check("rst_wr_count", {32'b0, wr_count}, 64'd0);
        check("rst_busy", {63'b0, busy}, 64'd1);
        @(negedge clk);
        clr = 1'b0;
        #1;
        count_busy(n);
        check("init_clear_cycles", 64'(n), 64'd16);
        check_show_all();
        chk_en = 1'b1;

        // Literal pins on the load model
        check("pin_raw", 64'(model_load(32'hA1B2C3D4, 4'b0110, 2'd0)), {31'b0, 1'b0, 32'h00B2C300});
        check("pin_sx16", 64'(model_load(32'hA1B2C3D4, 4'b1100, 2'd2)), {31'b0, 1'b0, 32'hFFFFA1B2});
        check("pin_zx16", 64'(model_load(32'hA1B2C3D4, 4'b1100, 2'd1)), {31'b0, 1'b0, 32'h0000A1B2});
        check("pin_sx8", 64'(model_load(32'hA1B2C3D4, 4'b0001, 2'd2)), {31'b0, 1'b0, 32'hFFFFFFD4});
        check("pin_noncontig", 64'(model_load(32'h00FF00FF, 4'b0101, 2'd1)), {31'b0, 1'b1, 32'h00FF00FF});
        check("pin_be0", 64'(model_load(32'h12345678, 4'b0000, 2'd0)), {31'b0, 1'b1, 32'h0});

        // T2: full store, then raw partial load
        do_req(1'b1, 4'd5, 32'hA1B2C3D4, 4'b1111, 2'd0);
        show_addr = 4'd5; #1;
        check("show_after_store", {32'b0, show_data}, {32'b0, 32'hA1B2C3D4});
        do_req(1'b0, 4'd5, 32'h0, 4'b0110, 2'd0);

        // T3: aligned loads of the same word
        do_req(1'b0, 4'd5, 32'h0, 4'b1100, 2'd2);
        do_req(1'b0, 4'd5, 32'h0, 4'b1100, 2'd1);
        do_req(1'b0, 4'd5, 32'h0, 4'b0001, 2'd2);
        do_req(1'b0, 4'd5, 32'h0, 4'b0011, 2'd2);
        do_req(1'b0, 4'd5, 32'h0, 4'b1110, 2'd1);
        do_req(1'b0, 4'd5, 32'h0, 4'b1010, 2'd3);

        // T4: partial store over zero, non-contiguous aligned load, be=0 cases
        do_req(1'b1, 4'd3, 32'hFFFFFFFF, 4'b0101, 2'd0);
        check("pin_partial_word", {32'b0, model_mem[3]}, {32'b0, 32'h00FF00FF});
        show_addr = 4'd3; #1;
        check("show_partial", {32'b0, show_data}, {32'b0, 32'h00FF00FF});
        do_req(1'b0, 4'd3, 32'h0, 4'b0101, 2'd1);
        do_req(1'b1, 4'd3, 32'h12345678, 4'b0000, 2'd0);
        do_req(1'b0, 4'd3, 32'h0, 4'b0000, 2'd2);
        do_req(1'b0, 4'd3, 32'h0, 4'b1111, 2'd0);
        check_show_all();

        // T5a: mem_clr wins over a same-cycle request
        do_req(1'b1, 4'd12, 32'hDEADBEEF, 4'b1111, 2'd0);
        @(negedge clk);
        mem_clr = 1'b1; req_valid = 1'b1; req_wr = 1'b1; addr = 4'd9; wdata = 32'h55555555; be = 4'hF;
        #1;
        check("ready_low_on_mem_clr", {63'b0, req_ready}, 64'd0);
        @(posedge clk); #1;
        mem_clr = 1'b0; req_valid = 1'b0;
        for (int a = 0; a < 16; a++) model_mem[a] = '0;
        @(negedge clk); #1;
        count_busy(n);
        check("mem_clr_cycles", 64'(n), 64'd16);
        check_show_all();

        // T5b: clr mid-clear restarts the sequence from pointer 0
        do_req(1'b1, 4'd2, 32'h01020304, 4'b1111, 2'd0);
        do_req(1'b1, 4'd14, 32'hCAFEF00D, 4'b1111, 2'd0);
        @(negedge clk);
        mem_clr = 1'b1;
        @(posedge clk); #1;
        mem_clr = 1'b0;
        repeat (5) @(negedge clk);
        chk_en = 1'b0;
        clr = 1'b1;
        exp_q.delete();
        mdl_rd = 0; mdl_wr = 0;
        for (int a = 0; a < 16; a++) model_mem[a] = '0;
        #2;
        clr = 1'b0;
        #1;
        chk_en = 1'b1;
        count_busy(n);
        check("restart_clear_cycles", 64'(n), 64'd16);
        check_show_all();

        // T6: counters over 3 stores and 2 loads (one with be=0)
        do_req(1'b1, 4'd1, 32'h11111111, 4'b1111, 2'd0);
        do_req(1'b0, 4'd1, 32'h0, 4'b0000, 2'd0);
        do_req(1'b1, 4'd2, 32'h22222222, 4'b0011, 2'd0);
        do_req(1'b1, 4'd1, 32'h33333333, 4'b1000, 2'd0);
        do_req(1'b0, 4'd1, 32'h0, 4'b1001, 2'd2);
        repeat (2) @(negedge clk);
        #1;
`ifdef DMEM_STATS_EN
        check("final_wr_count", {32'b0, wr_count}, 64'd3);
        check("final_rd_count", {32'b0, rd_count}, 64'd2);
`else
        check("final_wr_count", {32'b0, wr_count}, 64'd0);
        check("final_rd_count", {32'b0, rd_count}, 64'd0);
`endif
        check_show_all();
        repeat (2) @(negedge clk);
        chk_en = 1'b0;
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
